snn_spike_decoder: RTL and testbench
====================================

Name: snn_spike_decoder

Overview:
- Sits directly downstream of snn_core and consumes its output spike vector.
- Counts spikes per output neuron over a fixed time window, started by a start pulse.
- Performs a sequential argmax over the counts and presents the winning class, its count, and a tie flag.
- Results are handed off with a valid/ready handshake to the classification/readout logic.

Parameters:
- N_OUT, 10, number of output neurons (width of the spike vector from snn_core).
- CNT_W, 8, width of each per-neuron spike counter; counters saturate at 2^CNT_W-1.
- WINDOW, 100, number of spike-sampling cycles per inference window; legal range 1..65535.
- IDX_W, $clog2(N_OUT), width of the class index (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a new window; honoured only in IDLE.
- spikes_in  in  N_OUT  spike vector from snn_core spikes_out; bit i is neuron i.
- busy  out  1  high in ACCUM and ARGMAX.
- result_valid  out  1  result available; held until accepted.
- result_ready  in  1  consumer accepts the result.
- result_class  out  IDX_W  index of the winning neuron.
- result_count  out  CNT_W  spike count of the winning neuron.
- result_tie  out  1  at least one other neuron has a count equal to the maximum.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - All counters, window counter and scan index are 0.
  - busy, result_valid, result_class, result_count and result_tie are all 0.
  - Reset mid-window or mid-scan aborts the operation; no partial result is ever presented.
- FSM states are IDLE, ACCUM, ARGMAX, DONE.
- IDLE:
  - On a clk edge with start=1: clear all N_OUT counters and the window counter, then go to ACCUM.
  - spikes_in is ignored in IDLE.
- ACCUM:
  - Each cycle, counter[i] increments by 1 when spikes_in[i]=1, saturating at 2^CNT_W-1. There is no wrap-around.
  - The window counter increments every cycle.
  - If start edge is k, spikes are sampled on edges k+1 .. k+WINDOW, i.e. exactly WINDOW samples.
  - After the WINDOW-th sample, go to ARGMAX with scan index 0, running max = 0, best index = 0, tie = 0.
- ARGMAX: one neuron is compared per cycle, giving N_OUT cycles on edges k+WINDOW+1 .. k+WINDOW+N_OUT.
  - Index 0 loads max = counter[0], best = 0, tie = 0.
  - For i > 0 with counter[i] > max: max = counter[i], best = i, tie = 0.
  - For i > 0 with counter[i] == max: tie = 1 and best is unchanged, so the lowest index wins.
  - After index N_OUT-1, go to DONE.
- DONE:
  - result_valid rises after edge k+WINDOW+N_OUT. Total latency from the start edge to valid is WINDOW+N_OUT cycles.
  - result_class, result_count and result_tie are registered and stable while result_valid=1.
  - On an edge with result_valid=1 and result_ready=1: go to IDLE and deassert result_valid. Outputs keep their last value.
  - result_ready=1 while result_valid=1 on the same cycle that start=1: the handshake completes and start is ignored. A new start is accepted the following cycle in IDLE.
- start in ACCUM, ARGMAX or DONE is ignored, with no restart and no queueing.
- If every count is 0, the result is class 0, count 0, tie=1 (N_OUT>1).
- busy = (state==ACCUM) or (state==ARGMAX), registered.
- Counter storage is N_OUT registers of CNT_W bits; the ARGMAX compare uses a single multiplexer and comparator.

Decomposition:
- Shared package snn_pkg holds:
  - the state enum typedef decoder_state_t (IDLE, ACCUM, ARGMAX, DONE);
  - default N_OUT and CNT_W constants shared with snn_core;
  - the spike_vec_t typedef, logic [N_OUT-1:0].
- One natural sub-module, snn_sat_counter:
  - CNT_W-bit counter with synchronous clear, increment enable and saturation;
  - instantiated N_OUT times;
  - same clk and asynchronous active-low rst.

Test Plan:
- Reset, then start=1 for one cycle. spikes_in=10'b00_0000_1000 every cycle for 100 cycles.
  - Expect result_valid 110 cycles after the start edge, result_class=3, result_count=100, result_tie=0.
- Neuron 2 spikes on 40 cycles and neuron 7 on 40 cycles, others silent.
  - Expect class=2, count=40, tie=1.
- CNT_W=4, neuron 5 spikes every cycle.
  - Expect count=15 (saturated), class=5, tie=0.
- Drive no spikes at all.
  - Expect class=0, count=0, tie=1.
- Pulse start during ACCUM at cycle 50.
  - Expect it ignored, result_valid still at 110 cycles, busy high throughout.
- Hold result_ready=0 for 20 cycles after valid, pulsing start meanwhile.
  - Expect result_valid and all result fields stable, start ignored, and a return to IDLE one edge after result_ready=1.
- Assert rst low at cycle 60 of ACCUM.
  - Expect all outputs 0 immediately (asynchronous) and no result_valid afterwards.
  - A subsequent start then yields a correct fresh result.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network datapath: default sizes,
// spike vector type and the spike-decoder FSM state encoding.
package snn_pkg;

  localparam int SNN_N_OUT = 10;  // output neurons produced by snn_core
  localparam int SNN_CNT_W = 8;   // per-neuron spike counter width
  localparam int WIN_W     = 16;  // window counter width (WINDOW up to 65535)

  typedef logic [SNN_N_OUT-1:0] spike_vec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ARGMAX = 2'd2,
    DONE   = 2'd3
  } decoder_state_t;

  // The decoder is busy while it is collecting spikes or scanning counts.
  function automatic logic is_busy(input decoder_state_t s);
    return (s == ACCUM) || (s == ARGMAX);
  endfunction

endpackage

// File: rtl/snn_sat_counter.sv
// Saturating up-counter: synchronous clear, increment enable, holds at all-ones.
module snn_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,      // asynchronous, active low
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count;

  // Count spikes; clear wins over increment, and the value never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/snn_spike_decoder.sv
// Spike decoder: counts output spikes over a fixed window, then runs a
// one-neuron-per-cycle argmax and offers class/count/tie over valid/ready.
module snn_spike_decoder
  import snn_pkg::*;
#(
  parameter  int N_OUT  = SNN_N_OUT,
  parameter  int CNT_W  = SNN_CNT_W,
  parameter  int WINDOW = 100,
  localparam int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             clk,
  input  logic             rst,           // asynchronous, active low
  input  logic             start,
  input  logic [N_OUT-1:0] spikes_in,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [IDX_W-1:0] result_class,
  output logic [CNT_W-1:0] result_count,
  output logic             result_tie
);

  decoder_state_t   r_state;
  decoder_state_t   w_state_nxt;

  logic [WIN_W-1:0] r_win;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_max;
  logic [IDX_W-1:0] r_best;
  logic             r_tie;

  logic             r_busy;
  logic             r_valid;
  logic [IDX_W-1:0] r_class;
  logic [CNT_W-1:0] r_count;
  logic             r_res_tie;

  logic [CNT_W-1:0] w_cnt [N_OUT];
  logic [CNT_W-1:0] w_sel_cnt;
  logic             w_clr;
  logic             w_win_last;
  logic             w_scan_last;
  logic [CNT_W-1:0] w_max_nxt;
  logic [IDX_W-1:0] w_best_nxt;
  logic             w_tie_nxt;

  assign w_clr       = (r_state == IDLE) && start;
  assign w_win_last  = (r_win == WIN_W'(WINDOW - 1));
  assign w_scan_last = (r_idx == IDX_W'(N_OUT - 1));

  // One saturating counter per output neuron; they only count in ACCUM.
  for (genvar g = 0; g < N_OUT; g++) begin : g_cnt
    snn_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_clr),
      .i_inc   ((r_state == ACCUM) && spikes_in[g]),
      .o_count (w_cnt[g])
    );
  end

  // Single shared mux feeding the argmax comparator.
  assign w_sel_cnt = w_cnt[r_idx];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = ACCUM;
        else       w_state_nxt = IDLE;
      end
      ACCUM: begin
        if (w_win_last) w_state_nxt = ARGMAX;
        else            w_state_nxt = ACCUM;
      end
      ARGMAX: begin
        if (w_scan_last) w_state_nxt = DONE;
        else             w_state_nxt = ARGMAX;
      end
      DONE: begin
        // valid is always high in DONE, so ready alone completes the handshake
        if (result_ready) w_state_nxt = IDLE;
        else              w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Argmax step: strictly greater takes over, equal only flags a tie so the
  // lowest index keeps the win.
  always_comb begin
    w_max_nxt  = r_max;
    w_best_nxt = r_best;
    w_tie_nxt  = r_tie;
    if (r_idx == {IDX_W{1'b0}}) begin
      w_max_nxt  = w_sel_cnt;
      w_best_nxt = {IDX_W{1'b0}};
      w_tie_nxt  = 1'b0;
    end else if (w_sel_cnt > r_max) begin
      w_max_nxt  = w_sel_cnt;
      w_best_nxt = r_idx;
      w_tie_nxt  = 1'b0;
    end else if (w_sel_cnt == r_max) begin
      w_tie_nxt  = 1'b1;
    end else begin
      w_tie_nxt  = r_tie;
    end
  end

  // Window counter, scan registers and the registered result/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win     <= {WIN_W{1'b0}};
      r_idx     <= {IDX_W{1'b0}};
      r_max     <= {CNT_W{1'b0}};
      r_best    <= {IDX_W{1'b0}};
      r_tie     <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_class   <= {IDX_W{1'b0}};
      r_count   <= {CNT_W{1'b0}};
      r_res_tie <= 1'b0;
    end else begin
      r_busy  <= is_busy(w_state_nxt);
      r_valid <= (w_state_nxt == DONE);
      case (r_state)
        IDLE: begin
          if (start) r_win <= {WIN_W{1'b0}};
          else       r_win <= r_win;
        end
        ACCUM: begin
          r_win <= r_win + WIN_W'(1);
          if (w_win_last) begin
            r_idx  <= {IDX_W{1'b0}};
            r_max  <= {CNT_W{1'b0}};
            r_best <= {IDX_W{1'b0}};
            r_tie  <= 1'b0;
          end
        end
        ARGMAX: begin
          r_max  <= w_max_nxt;
          r_best <= w_best_nxt;
          r_tie  <= w_tie_nxt;
          r_idx  <= r_idx + IDX_W'(1);
          if (w_scan_last) begin
            r_class   <= w_best_nxt;
            r_count   <= w_max_nxt;
            r_res_tie <= w_tie_nxt;
          end
        end
        DONE: begin
          r_win <= r_win;
        end
        default: begin
          r_win <= {WIN_W{1'b0}};
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign result_valid = r_valid;
  assign result_class = r_class;
  assign result_count = r_count;
  assign result_tie   = r_res_tie;

endmodule

// File: tb/tb_snn_spike_decoder.sv
// Self-checking bench for snn_spike_decoder: randomized spike windows checked
// against a count-then-argmax reference model.
module tb_snn_spike_decoder;

  localparam int N  = 10;
  localparam int W  = 100;
  localparam int W4 = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, ready;
  logic [9:0] spikes;
  logic       busy, valid, tie;
  logic [3:0] cls;
  logic [7:0] cnt;

  logic       start4, ready4;
  logic [9:0] spikes4;
  logic       busy4, valid4, tie4;
  logic [3:0] cls4;
  logic [3:0] cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  int raw [N];
  int e_class, e_count;
  bit e_tie;
  int lat;
  int busy_bad;

  always #5 clk = ~clk;

  snn_spike_decoder dut (
    .clk(clk), .rst(rst), .start(start), .spikes_in(spikes), .busy(busy),
    .result_valid(valid), .result_ready(ready), .result_class(cls),
    .result_count(cnt), .result_tie(tie)
  );

  snn_spike_decoder #(.CNT_W(4), .WINDOW(W4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .spikes_in(spikes4), .busy(busy4),
    .result_valid(valid4), .result_ready(ready4), .result_class(cls4),
    .result_count(cnt4), .result_tie(tie4)
  );

  // ---------------- reference model ----------------
  function automatic void model_clear();
    for (int i = 0; i < N; i++) raw[i] = 0;
  endfunction

  function automatic void model_add(input logic [9:0] v);
    for (int i = 0; i < N; i++) if (v[i]) raw[i] = raw[i] + 1;
  endfunction

  // Saturate each count, take the maximum, the lowest index holding it, and
  // flag a tie when more than one neuron holds it.
  function automatic void model_eval(input int sat_max);
    int s [N];
    int m, holders;
    m = 0;
    for (int i = 0; i < N; i++) begin
      s[i] = (raw[i] > sat_max) ? sat_max : raw[i];
      if (s[i] > m) m = s[i];
    end
    holders = 0;
    e_class = -1;
    for (int i = 0; i < N; i++) begin
      if (s[i] == m) begin
        holders++;
        if (e_class < 0) e_class = i;
      end
    end
    e_count = m;
    e_tie   = (holders > 1);
  endfunction

  function automatic logic [9:0] gen(input int m, input int c);
    logic [31:0] r1, r2;
    logic [9:0]  v;
    r1 = $urandom;
    r2 = $urandom;
    v  = 10'd0;
    case (m)
      0: v = 10'b00_0000_1000;
      1: begin
        if (c < 40)            v[2] = 1'b1;
        if (c >= 50 && c < 90) v[7] = 1'b1;
      end
      2: v = 10'd0;
      3: v = r1[9:0];
      4: v = r1[9:0] & r2[9:0];
      default: v = 10'd0;
    endcase
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Start a window on the main DUT, feed W samples, wait for valid.
  // If rst_at >= 0, reset is asserted mid-cycle at that sample and the task returns.
  task automatic run(input int m, input int pulse_at, input int rst_at, output bit aborted);
    logic [9:0] v;
    model_clear();
    busy_bad = 0;
    aborted  = 1'b0;
    start  = 1'b1;
    spikes = gen(3, 0);               // ignored in IDLE
    @(posedge clk); #1;               // start edge k
    start = 1'b0;
    for (int c = 0; c < W; c++) begin
      if (busy !== 1'b1) busy_bad++;
      if (c == rst_at) begin
        #1 rst = 1'b0;
        aborted = 1'b1;
        return;
      end
      v = gen(m, c);
      spikes = v;
      model_add(v);
      start = (c == pulse_at);
      @(posedge clk); #1;
    end
    start  = 1'b0;
    spikes = gen(3, 0);               // ignored during the scan
    lat = W;
    while (valid !== 1'b1 && lat < W + N + 20) begin
      @(posedge clk); #1;
      lat++;
    end
    model_eval(255);
  endtask

  task automatic accept();
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; start = 1'b0; ready = 1'b0; spikes = 10'd0;
    start4 = 1'b0; ready4 = 1'b0; spikes4 = 10'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, valid, cls, cnt, tie} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b valid=%b class=%0d count=%0d tie=%b, want all 0",
               busy, valid, cls, cnt, tie);
    end
  endtask

  task automatic test_single_neuron();
    bit ab;
    run(0, -1, -1, ab);
    n_checks++;
    if (lat !== W + N) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", lat, W + N); end
    n_checks++;
    if (busy_bad !== 0) begin n_fail++; $display("FAIL single_busy: %0d cycles low, want 0", busy_bad); end
    n_checks++;
    if (cls !== e_class || e_class != 3) begin n_fail++; $display("FAIL single_class: got %0d want 3", cls); end
    n_checks++;
    if (cnt !== e_count || e_count != 100) begin n_fail++; $display("FAIL single_count: got %0d want 100", cnt); end
    n_checks++;
    if (tie !== 1'b0) begin n_fail++; $display("FAIL single_tie: got %b want 0", tie); end
    accept();
    n_checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_accept: got valid=%b busy=%b want 0 0", valid, busy);
    end
  endtask

  task automatic test_tie();
    bit ab;
    run(1, -1, -1, ab);
    n_checks++;
    if (cls !== 4'd2 || cnt !== 8'd40 || tie !== 1'b1) begin
      n_fail++; $display("FAIL tie_result: got class=%0d count=%0d tie=%b want 2 40 1", cls, cnt, tie);
    end
    accept();
  endtask

  task automatic test_zero();
    bit ab;
    run(2, -1, -1, ab);
    n_checks++;
    if (cls !== 4'd0 || cnt !== 8'd0 || tie !== 1'b1) begin
      n_fail++; $display("FAIL zero_result: got class=%0d count=%0d tie=%b want 0 0 1", cls, cnt, tie);
    end
    accept();
  endtask

  task automatic test_start_ignored();
    bit ab;
    run(3, 50, -1, ab);
    n_checks++;
    if (lat !== W + N) begin n_fail++; $display("FAIL restart_latency: got %0d want %0d", lat, W + N); end
    n_checks++;
    if (busy_bad !== 0) begin n_fail++; $display("FAIL restart_busy: %0d cycles low, want 0", busy_bad); end
    n_checks++;
    if (cls !== e_class || cnt !== e_count || tie !== e_tie) begin
      n_fail++; $display("FAIL restart_result: got %0d/%0d/%b want %0d/%0d/%b", cls, cnt, tie, e_class, e_count, e_tie);
    end
    accept();
  endtask

  task automatic test_random();
    bit ab;
    for (int t = 0; t < 4; t++) begin
      run(3 + (t % 2), -1, -1, ab);
      n_checks++;
      if (lat !== W + N || cls !== e_class || cnt !== e_count || tie !== e_tie) begin
        n_fail++;
        $display("FAIL random_%0d: got lat=%0d %0d/%0d/%b want lat=%0d %0d/%0d/%b",
                 t, lat, cls, cnt, tie, W + N, e_class, e_count, e_tie);
      end
      accept();
    end
  endtask

  task automatic test_ready_hold();
    bit ab;
    int bad;
    run(4, -1, -1, ab);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      ready = 1'b0;
      start = (c % 3 == 1);
      @(posedge clk); #1;
      if (valid !== 1'b1 || busy !== 1'b0 || cls !== e_class || cnt !== e_count || tie !== e_tie) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL hold_stable: %0d unstable cycles, want 0", bad); end
    ready = 1'b1;
    start = 1'b1;                     // same-cycle start must be dropped
    @(posedge clk); #1;
    ready = 1'b0;
    start = 1'b0;
    n_checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_handshake: got valid=%b busy=%b want 0 0", valid, busy);
    end
    n_checks++;
    if (cls !== e_class || cnt !== e_count || tie !== e_tie) begin
      n_fail++; $display("FAIL hold_keep: got %0d/%0d/%b want %0d/%0d/%b", cls, cnt, tie, e_class, e_count, e_tie);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_no_queue: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    bit ab;
    int bad;
    run(0, -1, -1, ab);
    accept();
    run(3, -1, 60, ab);
    #1;
    n_checks++;
    if (ab !== 1'b1 || {busy, valid, cls, cnt, tie} !== 15'd0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b valid=%b class=%0d count=%0d tie=%b want all 0",
               busy, valid, cls, cnt, tie);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 150; c++) begin
      @(posedge clk); #1;
      if (valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL reset_no_result: %0d cycles active, want 0", bad); end
    run(3, -1, -1, ab);
    n_checks++;
    if (lat !== W + N || cls !== e_class || cnt !== e_count || tie !== e_tie) begin
      n_fail++;
      $display("FAIL reset_fresh: got lat=%0d %0d/%0d/%b want lat=%0d %0d/%0d/%b",
               lat, cls, cnt, tie, W + N, e_class, e_count, e_tie);
    end
    accept();
  endtask

  task automatic test_saturation();
    int bad, l;
    model_clear();
    bad = 0;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int c = 0; c < W4; c++) begin
      if (busy4 !== 1'b1) bad++;
      spikes4 = 10'b00_0010_0000;
      model_add(spikes4);
      @(posedge clk); #1;
    end
    spikes4 = 10'd0;
    l = W4;
    while (valid4 !== 1'b1 && l < W4 + N + 20) begin
      @(posedge clk); #1;
      l++;
    end
    model_eval(15);
    n_checks++;
    if (l !== W4 + N || bad !== 0) begin
      n_fail++; $display("FAIL sat_timing: got latency=%0d busy_low=%0d want %0d 0", l, bad, W4 + N);
    end
    n_checks++;
    if (cls4 !== 4'd5 || cnt4 !== 4'd15 || tie4 !== 1'b0 || e_count != 15) begin
      n_fail++; $display("FAIL sat_result: got class=%0d count=%0d tie=%b want 5 15 0", cls4, cnt4, tie4);
    end
    ready4 = 1'b1;
    @(posedge clk); #1;
    ready4 = 1'b0;
    n_checks++;
    if (valid4 !== 1'b0) begin n_fail++; $display("FAIL sat_accept: got valid=%b want 0", valid4); end
  endtask

  initial begin
    test_reset();
    test_single_neuron();
    test_tie();
    test_zero();
    test_start_ignored();
    test_random();
    test_ready_hold();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
